// File: rtl/chess_pkg.sv
// Shared geometry, piece/state encodings and helpers for the chessboard sprite datapath.
package chess_pkg;

    localparam int SPRITE_H      = 60;
    localparam int SPRITE_V      = 60;
    localparam int SPRITE_PIXELS = SPRITE_H * SPRITE_V;
    localparam int FB_W          = 480;

    localparam logic [3:0] BLANK_CODE = 4'd12;

    typedef enum logic [2:0] {
        PAWN   = 3'd0,
        KNIGHT = 3'd1,
        BISHOP = 3'd2,
        ROOK   = 3'd3,
        QUEEN  = 3'd4,
        KING   = 3'd5
    } piece_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FETCH,
        DRAIN
    } blit_state_t;

    // Codes above the blank code have no sprite and draw as an empty square.
    function automatic logic [3:0] canon_code(input logic [3:0] code);
        return (code > BLANK_CODE) ? BLANK_CODE : code;
    endfunction

endpackage

// File: rtl/sq_addr_gen.sv
// Maps a pixel (x,y) inside board square (sq_row,sq_col) to its linear frame-buffer address.
module sq_addr_gen
    import chess_pkg::*;
(
    input  logic [2:0]  sq_row,
    input  logic [2:0]  sq_col,
    input  logic [5:0]  x,
    input  logic [5:0]  y,
    output logic [17:0] fb_addr
);

    logic [17:0] line;

    always_comb begin
        line    = 18'(sq_row) * 18'(SPRITE_V) + 18'(y);
        fb_addr = line * 18'(FB_W) + 18'(sq_col) * 18'(SPRITE_H) + 18'(x);
    end

endmodule

// File: rtl/square_blitter.sv
// Draws one 60x60 board square: parity-coloured background fill, then the piece sprite
// streamed from sprite_ram with transparent pixels skipped.
module square_blitter
    import chess_pkg::*;
#(
    parameter logic [3:0] LIGHT_IDX       = 4'h1,
    parameter logic [3:0] DARK_IDX        = 4'h2,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic [3:0]  piece_code,
    input  logic [2:0]  sq_row,
    input  logic [2:0]  sq_col,
    output logic        busy,
    output logic        done,
    output logic [3:0]  img_addr,
    output logic [11:0] pixel_addr,
    input  logic [3:0]  sprite_data,
    output logic        fb_we,
    output logic [17:0] fb_addr,
    output logic [3:0]  fb_data
);

    localparam logic [5:0] LAST_X = 6'(SPRITE_H - 1);
    localparam logic [5:0] LAST_Y = 6'(SPRITE_V - 1);

    blit_state_t state;
    logic [3:0]  code;
    logic [2:0]  row, col;
    logic [5:0]  x, y, next_x, next_y;
    logic [5:0]  dly_x, dly_y;
    logic        dly_valid;
    logic        x_wrap, last_px, fill_now;
    logic [5:0]  gen_x, gen_y;
    logic [3:0]  sq_colour;

    assign x_wrap    = (x == LAST_X);
    assign last_px   = x_wrap && (y == LAST_Y);
    assign next_x    = x_wrap ? 6'd0 : x + 6'd1;
    assign next_y    = x_wrap ? y + 6'd1 : y;
    assign fill_now  = (state == FILL);
    assign sq_colour = (row[0] ^ col[0]) ? DARK_IDX : LIGHT_IDX;

    // The fill pixel is addressed from the live counters; sprite pixels from the copy
    // delayed to line up with the ROM's one-cycle read latency.
    assign gen_x = fill_now ? x : dly_x;
    assign gen_y = fill_now ? y : dly_y;

    sq_addr_gen u_addr_gen (
        .sq_row  (row),
        .sq_col  (col),
        .x       (gen_x),
        .y       (gen_y),
        .fb_addr (fb_addr)
    );

    // NOTE: the write port is decoded from registered state plus the ROM data of this cycle;
    // registering it would push the last sprite write past the done pulse.
    assign fb_we   = fill_now | (dly_valid & (sprite_data != TRANSPARENT_IDX));
    assign fb_data = fill_now ? sq_colour : (dly_valid ? sprite_data : 4'd0);

    // NOTE: sequential state uses non-blocking assignments only, so every branch reads the
    // pre-edge values of x, y and state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            code       <= '0;
            row        <= '0;
            col        <= '0;
            x          <= '0;
            y          <= '0;
            dly_x      <= '0;
            dly_y      <= '0;
            dly_valid  <= 1'b0;
            img_addr   <= '0;
            pixel_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        code  <= canon_code(piece_code);
                        row   <= sq_row;
                        col   <= sq_col;
                        x     <= '0;
                        y     <= '0;
                        busy  <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (last_px) begin
                        x <= '0;
                        y <= '0;
                        if (code == BLANK_CODE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            img_addr   <= code;
                            pixel_addr <= '0;
                        end
                    end else begin
                        x <= next_x;
                        y <= next_y;
                    end
                end
                FETCH: begin
                    dly_x     <= x;
                    dly_y     <= y;
                    dly_valid <= 1'b1;
                    if (last_px) begin
                        x     <= '0;
                        y     <= '0;
                        state <= DRAIN;
                    end else begin
                        x          <= next_x;
                        y          <= next_y;
                        pixel_addr <= pixel_addr + 12'd1;
                    end
                end
                DRAIN: begin
                    dly_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_blitter.sv
// Self-checking bench for square_blitter: vector table, corner sequences and random squares
// compared against a frame-buffer write-list model built from the drawing rules.
module tb_square_blitter;

    localparam int LIGHT = 1;
    localparam int DARK  = 2;
    localparam int NONE  = 1_000_000;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  piece_code = '0;
    logic [2:0]  sq_row = '0;
    logic [2:0]  sq_col = '0;
    logic        busy, done, fb_we;
    logic [3:0]  img_addr, fb_data;
    logic [11:0] pixel_addr;
    logic [17:0] fb_addr;
    logic [3:0]  sprite_data = '0;

    square_blitter dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .start       (start),
        .piece_code  (piece_code),
        .sq_row      (sq_row),
        .sq_col      (sq_col),
        .busy        (busy),
        .done        (done),
        .img_addr    (img_addr),
        .pixel_addr  (pixel_addr),
        .sprite_data (sprite_data),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data)
    );

    always #5 CLK = ~CLK;

    // Sprite ROM content as a function of (sprite, pixel); mode picks the picture.
    int rom_mode = 0;
    int rom_salt = 1;

    function automatic int rom_val(input int mode, input int img, input int p, input int salt);
        int v;
        case (mode)
            0:       v = (p % 2 == 1) ? 5 : 0;
            1:       v = p % 16;
            default: v = (p * salt + img * 7 + p / 60) % 16;
        endcase
        return v;
    endfunction

    always @(posedge CLK)
        sprite_data <= 4'(rom_val(rom_mode, int'(img_addr), int'(pixel_addr), rom_salt));

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int pc;
        int row;
        int col;
        int mode;
        int first_addr;
        int last_addr;
        int nwr;
    } vec_t;

    wr_t wq[$];
    wr_t exp_q[$];
    int  rom_chg;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int px_addr(input int r, input int c, input int x, input int y);
        return (r * 60 + y) * 480 + c * 60 + x;
    endfunction

    // Reference: background of 3600 pixels in raster order, then every opaque sprite pixel.
    function automatic void build_exp(input int pc, input int r, input int c);
        int code;
        int colour;
        int d;
        code   = (pc > 12) ? 12 : pc;
        colour = ((r + c) % 2 == 0) ? LIGHT : DARK;
        exp_q.delete();
        for (int p = 0; p < 3600; p++)
            exp_q.push_back('{px_addr(r, c, p % 60, p / 60), colour});
        if (code != 12) begin
            for (int p = 0; p < 3600; p++) begin
                d = rom_val(rom_mode, code, p, rom_salt);
                if (d != 0) exp_q.push_back('{px_addr(r, c, p % 60, p / 60), d});
            end
        end
    endfunction

    task automatic launch(input int pc, input int r, input int c, input bit hold);
        @(negedge CLK);
        piece_code = 4'(pc);
        sq_row     = 3'(r);
        sq_col     = 3'(c);
        start      = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Observes one operation from the cycle after the accepting edge. Returns the index of
    // the done cycle, -1 on timeout, -2 when reset was applied at cycle abort_at.
    task automatic collect(input int abort_at, input int poke_at, output int lat);
        logic [3:0]  ia0;
        logic [11:0] pa0;
        wq.delete();
        rom_chg = 0;
        lat = -1;
        ia0 = '0;
        pa0 = '0;
        for (int n = 0; n < 8000; n++) begin
            @(negedge CLK);
            if (n == 0) begin
                ia0 = img_addr;
                pa0 = pixel_addr;
                check("busy_after_start", busy, 1);
            end else if (img_addr !== ia0 || pixel_addr !== pa0) begin
                rom_chg++;
            end
            if (fb_we) wq.push_back('{int'(fb_addr), int'(fb_data)});
            if (n == poke_at) begin
                piece_code = 4'd5;
                sq_row     = 3'd6;
                start      = 1'b1;
            end
            if (n == poke_at + 1) start = 1'b0;
            if (n == abort_at) begin
                RESET_N = 1'b0;
                #1;
                check("abort_fb_we", fb_we, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                lat = -2;
                break;
            end
            if (done) begin
                lat = n;
                check("busy_at_done", busy, 0);
                break;
            end
        end
        if (lat == -1) check("done_seen_within_budget", 0, 1);
    endtask

    task automatic compare(input string tag, input int pc, input int lat);
        int mism;
        int exp_lat;
        mism    = 0;
        exp_lat = (pc >= 12) ? 3600 : 7201;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_nwrites"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (wq[i].addr != exp_q[i].addr || wq[i].data != exp_q[i].data) mism++;
        check({tag, "_write_mismatches"}, mism, 0);
        if (pc >= 12) check({tag, "_rom_addr_changes"}, rom_chg, 0);
    endtask

    task automatic run_full(input string tag, input int pc, input int r, input int c);
        int lat;
        launch(pc, r, c, 1'b0);
        collect(NONE, NONE, lat);
        build_exp(pc, r, c);
        compare(tag, pc, lat);
        @(negedge CLK);
        check({tag, "_done_single_cycle"}, done, 0);
    endtask

    vec_t tbl[5];

    initial begin
        int lat;
        int quiet;

        tbl[0] = '{12, 0, 0, 0, 0,      28379,  3600};
        tbl[1] = '{3,  7, 7, 0, 202020, 230399, 5400};
        tbl[2] = '{15, 2, 5, 0, 57900,  86279,  3600};
        tbl[3] = '{6,  0, 1, 1, 60,     28439,  6975};
        tbl[4] = '{0,  4, 3, 1, 115380, 143759, 6975};

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_pixel_addr", pixel_addr, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        RESET_N = 1'b1;

        // Vector table: blank, piece, out-of-range code, and pixel-index ROM alignment
        foreach (tbl[i]) begin
            rom_mode = tbl[i].mode;
            run_full($sformatf("vec%0d", i), tbl[i].pc, tbl[i].row, tbl[i].col);
            check($sformatf("vec%0d_count", i), wq.size(), tbl[i].nwr);
            if (wq.size() > 0) begin
                check($sformatf("vec%0d_first_addr", i), wq[0].addr, tbl[i].first_addr);
                check($sformatf("vec%0d_last_addr", i), wq[wq.size() - 1].addr, tbl[i].last_addr);
            end else begin
                check($sformatf("vec%0d_has_writes", i), 0, 1);
            end
        end

        // Start pulse while busy must be ignored
        rom_mode = 0;
        launch(3, 1, 2, 1'b0);
        collect(NONE, 100, lat);
        build_exp(3, 1, 2);
        compare("busy_start_ignored", 3, lat);

        // Start held across done: next blit is accepted in the done cycle
        launch(12, 5, 5, 1'b1);
        collect(NONE, NONE, lat);
        check("held_first_latency", lat, 3600);
        piece_code = 4'd12;
        sq_row     = 3'd3;
        sq_col     = 3'd4;
        @(posedge CLK);
        #1;
        start = 1'b0;
        collect(NONE, NONE, lat);
        check("held_second_latency", lat, 3600);
        check("held_second_nwrites", wq.size(), 3600);
        if (wq.size() > 0) begin
            check("held_second_first_addr", wq[0].addr, 86640);
            check("held_second_first_data", wq[0].data, DARK);
        end

        // Reset in the middle of the sprite phase aborts cleanly
        rom_mode = 1;
        launch(9, 1, 6, 1'b0);
        collect(5000, NONE, lat);
        check("abort_taken", lat, -2);
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (fb_we || done || busy) quiet++;
        end
        check("abort_quiet_cycles", quiet, 0);
        RESET_N = 1'b1;
        run_full("after_reset", 4, 6, 1);

        // Random squares against a random sprite picture
        rom_mode = 2;
        for (int k = 0; k < 3; k++) begin
            int pc, r, c;
            pc       = int'($urandom_range(0, 15));
            r        = int'($urandom_range(0, 7));
            c        = int'($urandom_range(0, 7));
            rom_salt = int'($urandom_range(1, 15));
            run_full($sformatf("rand%0d_code%0d_r%0d_c%0d", k, pc, r, c), pc, r, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
